// File: rtl/edge_event_counter.sv
// rtl/edge_event_counter.sv - multi-channel synchronised edge event counter with per-channel readout
//
// Purpose:
//   Synchronises NCH asynchronous event inputs, detects rising/falling/both
//   edges according to MODE, and counts detected edges in per-channel
//   WIDTH-bit counters (wrapping or saturating) with sticky overflow flags.
//   One channel at a time is read out through SEL.
//
// Ports:
//   CLK      clock, all state on rising edge
//   RESET    synchronous active-high reset
//   EN       count enable (does not gate EDGE)
//   MODE     00 rising, 01 falling, 10 both, 11 detection off
//   CLR      synchronous clear of all counters and overflow flags
//   DIN      asynchronous event inputs, one per channel
//   SEL      channel select for COUNT/OVF readout
//   EDGE     registered one-cycle pulse per detected edge
//   COUNT    registered counter value of the selected channel
//   OVF      registered sticky overflow flag of the selected channel
//   ANY_OVF  registered OR of all channel overflow flags

module edge_event_counter #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   EN,
  input  logic [1:0]                             MODE,
  input  logic                                   CLR,
  input  logic [NCH-1:0]                         DIN,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] SEL,
  output logic [NCH-1:0]                         EDGE,
  output logic [WIDTH-1:0]                       COUNT,
  output logic                                   OVF,
  output logic                                   ANY_OVF
);

  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WARMW = $clog2(SYNC_STAGES + 2);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_hist;
  logic [WARMW-1:0]       r_warm;
  logic [WIDTH-1:0]       r_cnt [NCH];
  logic [NCH-1:0]         r_ovf;
  logic [NCH-1:0]         r_edge;
  logic [WIDTH-1:0]       r_count;
  logic                   r_ovf_sel;
  logic                   r_any_ovf;

  logic [NCH-1:0]         w_sync_last;
  logic [NCH-1:0]         w_rise;
  logic [NCH-1:0]         w_fall;
  logic [NCH-1:0]         w_detect;
  logic                   w_armed;
  logic [WIDTH-1:0]       w_sel_cnt;
  logic                   w_sel_ovf;

  always_comb begin
    w_sync_last = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sync_last[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  assign w_rise  = w_sync_last & ~r_hist;
  assign w_fall  = ~w_sync_last & r_hist;
  // Detection stays off until the sync chain and history have been refilled
  // from DIN, so a level held through reset never looks like an edge.
  assign w_armed = (r_warm == '0);

  always_comb begin
    w_detect = '0;
    if (w_armed) begin
      case (MODE)
        2'b00:   w_detect = w_rise;
        2'b01:   w_detect = w_fall;
        2'b10:   w_detect = w_rise | w_fall;
        default: w_detect = '0;
      endcase
    end
  end

  // Synchroniser chains, history and warm-up counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= '0;
      end
      r_hist <= '0;
      r_warm <= WARMW'(SYNC_STAGES + 1);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], DIN[i]};
      end
      r_hist <= w_sync_last;
      if (!w_armed) begin
        r_warm <= r_warm - WARMW'(1);
      end
    end
  end

  // Per-channel counters and sticky overflow flags; CLR beats a same-cycle edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf  <= '0;
      r_edge <= '0;
    end else begin
      r_edge <= w_detect;
      for (int i = 0; i < NCH; i++) begin
        if (CLR) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_detect[i] && EN) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
            if (SATURATE == 0) begin
              r_cnt[i] <= '0;
            end
          end else begin
            r_cnt[i] <= r_cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Readout mux; an out-of-range SEL matches no channel and reads as zero
  always_comb begin
    w_sel_cnt = '0;
    w_sel_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SEL == SELW'(i)) begin
        w_sel_cnt = r_cnt[i];
        w_sel_ovf = r_ovf[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count   <= '0;
      r_ovf_sel <= 1'b0;
      r_any_ovf <= 1'b0;
    end else begin
      r_count   <= w_sel_cnt;
      r_ovf_sel <= w_sel_ovf;
      r_any_ovf <= |r_ovf;
    end
  end

  assign EDGE    = r_edge;
  assign COUNT   = r_count;
  assign OVF     = r_ovf_sel;
  assign ANY_OVF = r_any_ovf;

endmodule

// File: tb/tb_edge_event_counter.sv
// tb/tb_edge_event_counter.sv - scoreboard bench for edge_event_counter

module tb_edge_event_counter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       EN;
  logic       CLR;
  logic [1:0] MODE;
  logic [3:0] DIN;
  logic [1:0] SEL;

  // default-parameter instance
  logic [3:0] m_edge;
  logic [7:0] m_count;
  logic       m_ovf;
  logic       m_any;
  // WIDTH=4 wrapping instance
  logic [3:0] w_edge;
  logic [3:0] w_count;
  logic       w_ovf;
  logic       w_any;
  // WIDTH=4 saturating instance
  logic [3:0] s_edge;
  logic [3:0] s_count;
  logic       s_ovf;
  logic       s_any;
  // NCH=3 instance
  logic [2:0] t_edge;
  logic [7:0] t_count;
  logic       t_ovf;
  logic       t_any;

  always #5 CLK = ~CLK;

  edge_event_counter dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .CLR(CLR), .DIN(DIN), .SEL(SEL),
    .EDGE(m_edge), .COUNT(m_count), .OVF(m_ovf), .ANY_OVF(m_any)
  );

  edge_event_counter #(.NCH(4), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(0)) dut_w (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .CLR(CLR), .DIN(DIN), .SEL(SEL),
    .EDGE(w_edge), .COUNT(w_count), .OVF(w_ovf), .ANY_OVF(w_any)
  );

  edge_event_counter #(.NCH(4), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(1)) dut_s (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .CLR(CLR), .DIN(DIN), .SEL(SEL),
    .EDGE(s_edge), .COUNT(s_count), .OVF(s_ovf), .ANY_OVF(s_any)
  );

  edge_event_counter #(.NCH(3), .WIDTH(8), .SYNC_STAGES(2), .SATURATE(0)) dut3 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .CLR(CLR), .DIN(DIN[2:0]), .SEL(SEL),
    .EDGE(t_edge), .COUNT(t_count), .OVF(t_ovf), .ANY_OVF(t_any)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int edge_seen [4] = '{default: 0};

  // EDGE pulse tally of the default instance, sampled mid-cycle
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (m_edge[i]) edge_seen[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got %0d with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    DIN[ch] = 1'b1;
    repeat (hi) tick();
    DIN[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic clear_all();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    tick();
  endtask

  int lat_e [4] = '{0, 0, 1, 0};
  int lat_c [4] = '{0, 0, 0, 1};
  int mode_exp [4] = '{5, 5, 10, 0};
  int e0;

  initial begin
    RESET = 1'b1; EN = 1'b1; CLR = 1'b0; MODE = 2'b00; DIN = 4'hF; SEL = 2'd0;
    repeat (3) tick();

    // reset state
    sb_push("rst_edge", 0);  sb_push("rst_count", 0);
    sb_push("rst_ovf", 0);   sb_push("rst_any", 0);
    pop_check(m_edge); pop_check(m_count); pop_check(m_ovf); pop_check(m_any);

    // warm-up with DIN held high through reset
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sb_push("warm_edge", 0);
      sb_push("warm_count", 0);
      tick();
      pop_check(m_edge);
      pop_check(m_count);
    end
    DIN = 4'h0;
    repeat (5) tick();
    sb_push("fall_ignored_count", 0);
    sb_push("no_edges_yet", 0);
    pop_check(m_count);
    pop_check(edge_seen[0] + edge_seen[1] + edge_seen[2] + edge_seen[3]);

    // latency: DIN[0] rises before edge k
    DIN[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_push("lat_edge", lat_e[i]);
      sb_push("lat_count", lat_c[i]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      pop_check(m_edge[0]);
      pop_check(m_count);
    end
    DIN[0] = 1'b0;
    repeat (4) tick();
    clear_all();

    // modes on channel 1
    SEL = 2'd1;
    for (int m = 0; m < 4; m++) begin
      MODE = 2'(m);
      e0 = edge_seen[1];
      sb_push("mode_count", mode_exp[m]);
      sb_push("mode_edges", mode_exp[m]);
      repeat (5) pulse(1, 2, 2);
      repeat (4) tick();
      pop_check(m_count);
      pop_check(edge_seen[1] - e0);
      clear_all();
    end

    // wrap vs saturate: 17 rising edges on channel 0
    MODE = 2'b00;
    SEL  = 2'd0;
    sb_push("wrap_count", 1);  sb_push("wrap_ovf", 1);  sb_push("wrap_any", 1);
    sb_push("sat_count", 15);  sb_push("sat_ovf", 1);   sb_push("sat_any", 1);
    sb_push("w8_count", 17);   sb_push("w8_ovf", 0);
    repeat (17) pulse(0, 1, 1);
    repeat (4) tick();
    pop_check(w_count); pop_check(w_ovf); pop_check(w_any);
    pop_check(s_count); pop_check(s_ovf); pop_check(s_any);
    pop_check(m_count); pop_check(m_ovf);

    // back-to-back edges at full rate on channel 2
    MODE = 2'b10;
    SEL  = 2'd2;
    e0 = edge_seen[2];
    sb_push("b2b_count", 6);
    sb_push("b2b_edges", 6);
    for (int i = 0; i < 6; i++) begin
      DIN[2] = ~DIN[2];
      tick();
    end
    repeat (4) tick();
    pop_check(m_count);
    pop_check(edge_seen[2] - e0);
    MODE = 2'b00;

    // CLR colliding with a counted edge on channel 3
    SEL = 2'd3;
    sb_push("pre_clr_count", 2);
    repeat (2) pulse(3, 2, 2);
    repeat (3) tick();
    pop_check(m_count);
    DIN[3] = 1'b1;
    tick();
    tick();
    CLR = 1'b1;
    sb_push("coll_edge", 1);
    tick();
    pop_check(m_edge[3]);
    CLR = 1'b0;
    sb_push("coll_count", 0); sb_push("coll_ovf", 0); sb_push("coll_w_any", 0);
    tick();
    pop_check(m_count); pop_check(m_ovf); pop_check(w_any);
    sb_push("coll_count_hold", 0);
    repeat (2) tick();
    pop_check(m_count);
    DIN[3] = 1'b0;
    repeat (4) tick();

    // EN=0: edges still pulse, count unchanged
    EN = 1'b0;
    e0 = edge_seen[3];
    sb_push("en0_count", 0);
    sb_push("en0_edges", 3);
    repeat (3) pulse(3, 2, 2);
    repeat (4) tick();
    pop_check(m_count);
    pop_check(edge_seen[3] - e0);
    EN = 1'b1;

    // readout sweep: channel i gets i+1 edges
    clear_all();
    for (int ch = 0; ch < 4; ch++) begin
      repeat (ch + 1) pulse(ch, 2, 2);
    end
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      SEL = 2'(i);
      sb_push("sel_count", i + 1);
      sb_push("sel3_count", (i < 3) ? i + 1 : 0);
      sb_push("sel3_ovf", 0);
      tick();
      pop_check(m_count);
      pop_check(t_count);
      pop_check(t_ovf);
    end

    // mid-operation reset
    SEL = 2'd0;
    repeat (16) pulse(0, 1, 1);
    repeat (4) tick();
    sb_push("pre_rst_w_any", 1);
    sb_push("pre_rst_count", 17);
    pop_check(w_any);
    pop_check(m_count);
    DIN[1] = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    CLR   = 1'b0;
    sb_push("mid_rst_edge", 0);  sb_push("mid_rst_count", 0);
    sb_push("mid_rst_ovf", 0);   sb_push("mid_rst_any", 0);
    sb_push("mid_rst_w_any", 0); sb_push("mid_rst_w_count", 0);
    tick();
    pop_check(m_edge); pop_check(m_count); pop_check(m_ovf); pop_check(m_any);
    pop_check(w_any);  pop_check(w_count);
    RESET = 1'b0;
    DIN = 4'h0;
    repeat (5) tick();

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected entries never compared", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
